// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO controllers: Gray/binary
// pointer conversion at a fixed maximum width. Callers zero-extend on
// the way in and truncate on the way out.
package fifo_pkg;

    // Widest pointer any FIFO controller instance may use.
    localparam int PTR_MAX_W = 16;

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended Gray codes convert correctly because the leading
    // zeros contribute nothing to the running XOR.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b = '0;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded bus crossing into this clock
// domain. Nothing may sit between d_i and the first flop.
module sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;

    // Two back-to-back capture stages, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= d_i;
            stage2_q <= stage1_q;
        end
    end

    assign q_o = stage2_q;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of the dual-clock FIFO: write pointers,
// read-pointer synchronization, full / almost-full / level / overflow.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int FIFO_Depth = 16,
    parameter int FIFO_addr  = 5,
    parameter int AF_MARGIN  = 2
) (
    input  logic                 wr_clk,
    input  logic                 wr_reset,
    input  logic                 wr_en,
    input  logic                 wr_ovf_clr,
    input  logic [FIFO_addr-1:0] rd_ptr_gray,
    output logic                 wr_accept,
    output logic [FIFO_addr-1:0] wr_addr,
    output logic [FIFO_addr-1:0] wr_ptr_gray,
    output logic                 wr_full,
    output logic                 wr_almost_full,
    output logic [FIFO_addr-1:0] wr_level,
    output logic                 wr_overflow
);

    localparam logic [FIFO_addr-1:0] AF_LEVEL = FIFO_addr'(FIFO_Depth - AF_MARGIN);

    logic [FIFO_addr-1:0] wr_bin_q,   wr_bin_d;
    logic [FIFO_addr-1:0] wr_gray_q,  wr_gray_d;
    logic [FIFO_addr-1:0] level_q,    level_d;
    logic                 full_q,     full_d;
    logic                 afull_q,    afull_d;
    logic                 ovf_q,      ovf_d;
    logic [FIFO_addr-1:0] rq2;
    logic [FIFO_addr-1:0] rd_bin_s;
    logic [FIFO_addr-1:0] full_pattern;

    // Read pointer enters this domain only through the synchronizer.
    sync_2ff #(
        .WIDTH (FIFO_addr)
    ) u_rd_sync (
        .clk_i (wr_clk),
        .rst_i (wr_reset),
        .d_i   (rd_ptr_gray),
        .q_o   (rq2)
    );

    assign wr_accept = wr_en & ~full_q;

    // Next pointer, level and flag values computed from the current state.
    always_comb begin
        wr_bin_d     = wr_bin_q + FIFO_addr'(wr_accept);
        wr_gray_d    = FIFO_addr'(bin2gray(PTR_MAX_W'(wr_bin_d)));
        rd_bin_s     = FIFO_addr'(gray2bin(PTR_MAX_W'(rq2)));
        // Full when the write pointer is one lap ahead: top two Gray bits
        // inverted, the rest equal.
        full_pattern = {~rq2[FIFO_addr-1:FIFO_addr-2], rq2[FIFO_addr-3:0]};
        full_d       = (wr_gray_d == full_pattern);
        level_d      = wr_bin_d - rd_bin_s;
        afull_d      = (level_d >= AF_LEVEL);
        // A write attempted while full takes priority over the clear.
        ovf_d        = ovf_q;
        if (wr_en && full_q) begin
            ovf_d = 1'b1;
        end else if (wr_ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Registered write-domain state, cleared asynchronously.
    always_ff @(posedge wr_clk or posedge wr_reset) begin
        if (wr_reset) begin
            wr_bin_q  <= '0;
            wr_gray_q <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_bin_q  <= wr_bin_d;
            wr_gray_q <= wr_gray_d;
            level_q   <= level_d;
            full_q    <= full_d;
            afull_q   <= afull_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage index drops the wrap bit so it stays within 0..FIFO_Depth-1.
    assign wr_addr        = {1'b0, wr_bin_q[FIFO_addr-2:0]};
    assign wr_ptr_gray    = wr_gray_q;
    assign wr_full        = full_q;
    assign wr_almost_full = afull_q;
    assign wr_level       = level_q;
    assign wr_overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
`timescale 1ns/1ps
module tb_fifo_wr_ctrl;

    logic       wr_clk = 1'b0;
    logic       rd_clk = 1'b0;
    logic       wr_reset = 1'b1;
    logic       wr_en = 1'b0;
    logic       wr_ovf_clr = 1'b0;
    logic [4:0] rd_ptr_gray = 5'd0;
    logic       wr_accept;
    logic [4:0] wr_addr;
    logic [4:0] wr_ptr_gray;
    logic       wr_full;
    logic       wr_almost_full;
    logic [4:0] wr_level;
    logic       wr_overflow;

    int total = 0;
    int bad   = 0;

    // Gray codes of 1..16, written out by hand.
    logic [4:0] gtab [16] = '{5'b00001, 5'b00011, 5'b00010, 5'b00110,
                              5'b00111, 5'b00101, 5'b00100, 5'b01100,
                              5'b01101, 5'b01111, 5'b01110, 5'b01010,
                              5'b01011, 5'b01001, 5'b01000, 5'b11000};

    int wcnt = 0;
    int rcnt = 0;
    bit rnd_done = 1'b0;

    fifo_wr_ctrl #(
        .FIFO_Depth (16),
        .FIFO_addr  (5),
        .AF_MARGIN  (2)
    ) dut (
        .wr_clk         (wr_clk),
        .wr_reset       (wr_reset),
        .wr_en          (wr_en),
        .wr_ovf_clr     (wr_ovf_clr),
        .rd_ptr_gray    (rd_ptr_gray),
        .wr_accept      (wr_accept),
        .wr_addr        (wr_addr),
        .wr_ptr_gray    (wr_ptr_gray),
        .wr_full        (wr_full),
        .wr_almost_full (wr_almost_full),
        .wr_level       (wr_level),
        .wr_overflow    (wr_overflow)
    );

    always #5   wr_clk = ~wr_clk;
    always #3.5 rd_clk = ~rd_clk;

    function automatic logic [4:0] g5(input int v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic step();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic do_reset();
        wr_en = 1'b0;
        wr_ovf_clr = 1'b0;
        rd_ptr_gray = 5'd0;
        wr_reset = 1'b1;
        #3;
        wr_reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        #2;
        total++; if ({wr_addr, wr_ptr_gray, wr_level} !== 15'd0) begin bad++; $display("FAIL reset_ptrs got %h exp 0", {wr_addr, wr_ptr_gray, wr_level}); end
        total++; if ({wr_full, wr_almost_full, wr_overflow, wr_accept} !== 4'b0000) begin bad++; $display("FAIL reset_flags got %b exp 0000", {wr_full, wr_almost_full, wr_overflow, wr_accept}); end
        #20;
        wr_reset = 1'b0;
        step();
        total++; if (wr_level !== 5'd0) begin bad++; $display("FAIL reset_level_after got %0d exp 0", wr_level); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            #1;
            total++; if (wr_addr !== 5'(i)) begin bad++; $display("FAIL fill_addr[%0d] got %0d exp %0d", i, wr_addr, i); end
            total++; if (wr_accept !== 1'b1) begin bad++; $display("FAIL fill_accept[%0d] got %b exp 1", i, wr_accept); end
            step();
            total++; if (wr_ptr_gray !== gtab[i]) begin bad++; $display("FAIL fill_gray[%0d] got %b exp %b", i, wr_ptr_gray, gtab[i]); end
            total++; if (wr_level !== 5'(i + 1)) begin bad++; $display("FAIL fill_level[%0d] got %0d exp %0d", i, wr_level, i + 1); end
            total++; if (wr_full !== (i == 15)) begin bad++; $display("FAIL fill_full[%0d] got %b exp %b", i, wr_full, (i == 15)); end
            total++; if (wr_almost_full !== (i >= 13)) begin bad++; $display("FAIL fill_afull[%0d] got %b exp %b", i, wr_almost_full, (i >= 13)); end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            #1;
            total++; if (wr_accept !== 1'b0) begin bad++; $display("FAIL ovf_accept[%0d] got %b exp 0", i, wr_accept); end
            step();
            total++; if (wr_ptr_gray !== 5'b11000 || wr_addr !== 5'd0) begin bad++; $display("FAIL ovf_ptr[%0d] got %b/%0d exp 11000/0", i, wr_ptr_gray, wr_addr); end
            total++; if (wr_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag[%0d] got %b exp 1", i, wr_overflow); end
            total++; if (wr_full !== 1'b1 || wr_level !== 5'd16) begin bad++; $display("FAIL ovf_full[%0d] got %b/%0d exp 1/16", i, wr_full, wr_level); end
        end
        wr_en = 1'b1;
        wr_ovf_clr = 1'b1;
        step();
        total++; if (wr_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got %b exp 1", wr_overflow); end
        wr_en = 1'b0;
        step();
        total++; if (wr_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got %b exp 0", wr_overflow); end
        wr_ovf_clr = 1'b0;
    endtask

    task automatic test_drain();
        rd_ptr_gray = 5'b00110;
        step();
        total++; if (wr_full !== 1'b1) begin bad++; $display("FAIL drain_edge1 got %b exp 1", wr_full); end
        step();
        total++; if (wr_full !== 1'b1 || wr_level !== 5'd16) begin bad++; $display("FAIL drain_edge2 got %b/%0d exp 1/16", wr_full, wr_level); end
        step();
        total++; if (wr_full !== 1'b0) begin bad++; $display("FAIL drain_edge3_full got %b exp 0", wr_full); end
        total++; if (wr_level !== 5'd12) begin bad++; $display("FAIL drain_edge3_level got %0d exp 12", wr_level); end
        total++; if (wr_almost_full !== 1'b0) begin bad++; $display("FAIL drain_edge3_afull got %b exp 0", wr_almost_full); end
    endtask

    // Reader consumes everything written so far; level settles at 3 from sync lag.
    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1;
            rd_ptr_gray = g5(i);
            #1;
            total++; if (wr_addr !== 5'(i % 16)) begin bad++; $display("FAIL wrap_addr[%0d] got %0d exp %0d", i, wr_addr, i % 16); end
            total++; if (wr_accept !== 1'b1) begin bad++; $display("FAIL wrap_accept[%0d] got %b exp 1", i, wr_accept); end
            step();
            total++; if (wr_full !== 1'b0) begin bad++; $display("FAIL wrap_full[%0d] got %b exp 0", i, wr_full); end
            total++; if (wr_level !== 5'((i < 2) ? i + 1 : 3)) begin bad++; $display("FAIL wrap_level[%0d] got %0d exp %0d", i, wr_level, (i < 2) ? i + 1 : 3); end
            total++; if (wr_ptr_gray[4] !== (i >= 15)) begin bad++; $display("FAIL wrap_msb[%0d] got %b exp %b", i, wr_ptr_gray[4], (i >= 15)); end
        end
        wr_en = 1'b0;
        total++; if (wr_ptr_gray !== 5'b11110) begin bad++; $display("FAIL wrap_final_gray got %b exp 11110", wr_ptr_gray); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wr_en = 1'b1;
        repeat (9) step();
        wr_en = 1'b0;
        total++; if (wr_level !== 5'd9) begin bad++; $display("FAIL mid_level_pre got %0d exp 9", wr_level); end
        #2;
        wr_reset = 1'b1;
        #1;
        total++; if ({wr_addr, wr_ptr_gray, wr_level} !== 15'd0) begin bad++; $display("FAIL mid_async_ptrs got %h exp 0", {wr_addr, wr_ptr_gray, wr_level}); end
        total++; if ({wr_full, wr_almost_full, wr_overflow} !== 3'b000) begin bad++; $display("FAIL mid_async_flags got %b exp 000", {wr_full, wr_almost_full, wr_overflow}); end
        #2;
        wr_reset = 1'b0;
        step();
        wr_en = 1'b1;
        #1;
        total++; if (wr_addr !== 5'd0 || wr_accept !== 1'b1) begin bad++; $display("FAIL mid_first_write got %0d/%b exp 0/1", wr_addr, wr_accept); end
        step();
        wr_en = 1'b0;
        total++; if (wr_ptr_gray !== 5'b00001 || wr_level !== 5'd1) begin bad++; $display("FAIL mid_after_write got %b/%0d exp 00001/1", wr_ptr_gray, wr_level); end
    endtask

    task automatic test_random();
        logic [4:0] prev_gray;
        bit acc_pending;
        do_reset();
        wcnt = 0;
        rcnt = 0;
        rnd_done = 1'b0;
        acc_pending = 1'b0;
        prev_gray = wr_ptr_gray;
        fork
            begin
                for (int c = 0; c < 400; c++) begin
                    @(posedge wr_clk);
                    #1;
                    if (acc_pending) wcnt++;
                    total++; if (wcnt - rcnt == 16 && wr_full !== 1'b1) begin bad++; $display("FAIL rnd_full[%0d] got %b exp 1 occ=16", c, wr_full); end
                    total++; if ($countones(prev_gray ^ wr_ptr_gray) > 1) begin bad++; $display("FAIL rnd_hamming[%0d] got %b after %b", c, wr_ptr_gray, prev_gray); end
                    total++; if (wr_level > 5'd16) begin bad++; $display("FAIL rnd_level[%0d] got %0d exp <=16", c, wr_level); end
                    prev_gray = wr_ptr_gray;
                    wr_en = ($urandom_range(0, 1) == 1);
                    #1;
                    acc_pending = wr_accept;
                end
                wr_en = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge rd_clk);
                    #1;
                    if ((wcnt - rcnt > 0) && ($urandom_range(0, 3) == 0)) begin
                        rcnt++;
                        rd_ptr_gray = g5(rcnt);
                    end
                end
            end
        join
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
